mem_wb_skid_stage: RTL and testbench
====================================

# mem_wb_skid_stage

Parametrised MEM→WB pipeline stage for the N-issue core. It registers LANES parallel memory-stage results and adds a valid/ready handshake with a two-entry skid buffer, so writeback can stall without a combinational ready path into MEM. It also supports per-lane and whole-stage flush, and produces the selected writeback data and an x0-filtered write enable per lane. It sits between the memory stage and the register-file write ports.

## Interface
- LANES, 2, number of issue lanes (≥1)
- XLEN, 32, datapath width
- REG_AW, 5, register-address width
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- m_valid_i  in  1  MEM bundle valid
- m_ready_o  out  1  stage can accept; registered, no combinational path from w_ready_i
- m_lane_valid_i  in  LANES  per-lane instruction present
- m_flush_i  in  LANES  squash the incoming lane on accept
- flush_all_i  in  1  synchronous clear of the whole stage
- m_regwrite_i  in  LANES  per-lane RegWrite
- m_result_src_i  in  LANES×2  per-lane ResultSrc
- m_alu_result_i, m_read_data_i, m_pc_plus8_i  in  LANES×XLEN  per-lane operands
- m_rd_i  in  LANES×REG_AW  per-lane destination
- w_valid_o  out  1  WB bundle valid
- w_ready_i  in  1  WB consumes the bundle
- w_lane_valid_o  out  LANES  per-lane valid
- w_we_o  out  LANES  lane_valid & regwrite & (rd≠0)
- w_rd_o  out  LANES×REG_AW  destination
- w_result_o  out  LANES×XLEN  selected writeback data

## Operation
- Accept occurs when m_valid_i & m_ready_o; transfer occurs when w_valid_o & w_ready_i.
- Storage consists of a main register (drives outputs) and a skid register.
- FSM has three states: EMPTY, FULL (main only), SKID (main and skid).
  - EMPTY: on accept, main ← in and go to FULL.
  - FULL, transfer & accept: main ← in, stay FULL.
  - FULL, transfer only: go to EMPTY.
  - FULL, accept only: skid ← in, go to SKID.
  - FULL, neither: hold.
  - SKID, transfer: main ← skid, go to FULL. No accept is possible in SKID.
  - SKID, no transfer: hold.
- m_ready_o = (state ≠ SKID). w_valid_o = (state ≠ EMPTY).
- Per-lane flush: a lane with m_flush_i=1 at accept is stored with lane_valid=0, regwrite=0 and zero payload. The bundle is still accepted, which preserves ordering.
- A bundle with all lanes invalid is a legal bundle and passes through.
- Result select per lane (combinational from main): 00 → alu_result, 01 → read_data, 10 → pc_plus8, 11 → 0.
- w_we_o is forced to 0 when rd=0, lane_valid=0, or state=EMPTY.
- Priority: rst_n low > flush_all_i > handshake.
- flush_all_i drops everything: state ← EMPTY, main and skid cleared, and any m_valid_i in the same cycle is discarded.

## Timing
- Reset (rst_n=0 at posedge): state=EMPTY and all storage is zero.
  - Outputs after reset: w_valid_o=0, w_lane_valid_o=0, w_we_o=0, w_rd_o=0, w_result_o=0, m_ready_o=1.
  - Reset mid-operation discards both entries in one cycle.
- Latency: accept in EMPTY at edge N gives w_valid_o=1 after edge N (1 cycle).
- Throughput: 1 bundle/cycle while w_ready_i stays high.
- Stall: w_ready_i low with one entry held → one more bundle lands in skid; m_ready_o drops after that edge.
- Release: first transfer returns to FULL and m_ready_o rises the next cycle; the second bundle appears on the cycle after the first transfer.
- Bundles are never lost or duplicated. Output payload is stable while w_valid_o & !w_ready_i.
- flush_all_i takes effect at the same edge; w_valid_o=0 and m_ready_o=1 the following cycle.

## Structure
- Shared package pipe_pkg holds:
  - result_src_e: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC8=2'b10.
  - wb_lane_t struct {lane_valid, regwrite, result_src, alu_result, read_data, rd, pc_plus8}, sized by XLEN/REG_AW package constants.
- Sub-module wb_result_mux: one instance per lane via generate, purely combinational. It implements the result select and w_we_o.
- The FSM and the main/skid arrays (wb_lane_t [LANES]) live in the top module.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with m_valid_i=1 → w_valid_o=0, all outputs 0, m_ready_o=1; no bundle captured.
- Streaming: LANES=2, w_ready_i=1, three bundles with alu_result 0x10/0x20/0x30 and ResultSrc=00 → w_result_o appears in order, each 1 cycle after its accept.
- Skid: w_ready_i=0, send A then B.
  - After B: m_ready_o=0 and output holds A.
  - Raise w_ready_i: A then B transfer on consecutive cycles.
  - m_ready_o=1 one cycle after A's transfer.
- Flush and x0 filter:
  - Lane1 m_flush_i=1 → w_lane_valid_o=2'b01, w_we_o[1]=0.
  - Lane0 rd=0 with regwrite=1 → w_we_o[0]=0.
- Result select: read_data=0xDEADBEEF with src=01 → 0xDEADBEEF; pc_plus8=0x108 with src=10 → 0x108; src=11 → 0.
- flush_all_i in SKID state together with m_valid_i=1 → next cycle w_valid_o=0, m_ready_o=1, and no stale bundle emitted afterwards.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared MEM->WB pipeline types: result-source encoding, per-lane writeback
// payload and the skid-stage state encoding.
package pipe_pkg;

    localparam int PIPE_XLEN   = 32;
    localparam int PIPE_REG_AW = 5;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC8 = 2'b10
    } result_src_e;

    // result_src is kept as raw bits: 2'b11 is a legal encoding that selects zero
    typedef struct packed {
        logic                   lane_valid;
        logic                   regwrite;
        logic [1:0]             result_src;
        logic [PIPE_XLEN-1:0]   alu_result;
        logic [PIPE_XLEN-1:0]   read_data;
        logic [PIPE_REG_AW-1:0] rd;
        logic [PIPE_XLEN-1:0]   pc_plus8;
    } wb_lane_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKID
    } stage_state_e;

endpackage

// File: rtl/wb_result_mux.sv
// Per-lane writeback data select and x0-filtered register write enable.
module wb_result_mux
    import pipe_pkg::*;
(
    input  wb_lane_t               lane,
    input  logic                   stage_valid,
    output logic [PIPE_XLEN-1:0]   result,
    output logic                   we
);

    // Select writeback data by ResultSrc; the unused encoding yields zero
    always_comb begin
        result = '0;
        case (lane.result_src)
            RES_ALU: result = lane.alu_result;
            RES_MEM: result = lane.read_data;
            RES_PC8: result = lane.pc_plus8;
            default: result = '0;
        endcase
    end

    // Never write x0, an absent lane or from an empty stage
    always_comb begin
        we = stage_valid & lane.lane_valid & lane.regwrite & (lane.rd != '0);
    end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB register stage with a two-entry skid buffer so that m_ready_o is a
// pure decode of registered state, plus per-lane and whole-stage flush.
module mem_wb_skid_stage
    import pipe_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int XLEN   = PIPE_XLEN,
    parameter int REG_AW = PIPE_REG_AW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m_valid_i,
    output logic                    m_ready_o,
    input  logic [LANES-1:0]        m_lane_valid_i,
    input  logic [LANES-1:0]        m_flush_i,
    input  logic                    flush_all_i,
    input  logic [LANES-1:0]        m_regwrite_i,
    input  logic [LANES*2-1:0]      m_result_src_i,
    input  logic [LANES*XLEN-1:0]   m_alu_result_i,
    input  logic [LANES*XLEN-1:0]   m_read_data_i,
    input  logic [LANES*XLEN-1:0]   m_pc_plus8_i,
    input  logic [LANES*REG_AW-1:0] m_rd_i,
    output logic                    w_valid_o,
    input  logic                    w_ready_i,
    output logic [LANES-1:0]        w_lane_valid_o,
    output logic [LANES-1:0]        w_we_o,
    output logic [LANES*REG_AW-1:0] w_rd_o,
    output logic [LANES*XLEN-1:0]   w_result_o
);

    stage_state_e state, state_n;
    wb_lane_t     main   [LANES];
    wb_lane_t     skid   [LANES];
    wb_lane_t     main_n [LANES];
    wb_lane_t     skid_n [LANES];
    wb_lane_t     in_lane[LANES];
    logic         accept;
    logic         xfer;

    assign m_ready_o = (state != ST_SKID);
    assign w_valid_o = (state != ST_EMPTY);
    assign accept    = m_valid_i & m_ready_o;
    assign xfer      = w_valid_o & w_ready_i;

    // Unpack incoming lanes; a squashed lane is stored as an all-zero bubble
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            in_lane[i] = '0;
            if (!m_flush_i[i]) begin
                in_lane[i].lane_valid = m_lane_valid_i[i];
                in_lane[i].regwrite   = m_regwrite_i[i];
                in_lane[i].result_src = m_result_src_i[i*2 +: 2];
                in_lane[i].alu_result = m_alu_result_i[i*XLEN +: XLEN];
                in_lane[i].read_data  = m_read_data_i[i*XLEN +: XLEN];
                in_lane[i].pc_plus8   = m_pc_plus8_i[i*XLEN +: XLEN];
                in_lane[i].rd         = m_rd_i[i*REG_AW +: REG_AW];
            end
        end
    end

    // Next state and next main/skid contents from the accept/transfer pair
    always_comb begin
        state_n = state;
        main_n  = main;
        skid_n  = skid;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    main_n  = in_lane;
                    state_n = ST_FULL;
                end
            end
            ST_FULL: begin
                if (xfer && accept) begin
                    main_n = in_lane;
                end else if (xfer) begin
                    // clearing main keeps every output at zero while empty
                    main_n  = '{default: '0};
                    state_n = ST_EMPTY;
                end else if (accept) begin
                    skid_n  = in_lane;
                    state_n = ST_SKID;
                end
            end
            ST_SKID: begin
                if (xfer) begin
                    main_n  = skid;
                    skid_n  = '{default: '0};
                    state_n = ST_FULL;
                end
            end
            default: begin
                state_n = ST_EMPTY;
                main_n  = '{default: '0};
                skid_n  = '{default: '0};
            end
        endcase
    end

    // State and storage registers; reset and flush_all drop both entries
    always_ff @(posedge clk) begin
        if (!rst_n || flush_all_i) begin
            state <= ST_EMPTY;
            main  <= '{default: '0};
            skid  <= '{default: '0};
        end else begin
            state <= state_n;
            main  <= main_n;
            skid  <= skid_n;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [PIPE_XLEN-1:0] lane_result;
        logic                 lane_we;

        wb_result_mux u_mux (
            .lane        (main[g]),
            .stage_valid (w_valid_o),
            .result      (lane_result),
            .we          (lane_we)
        );

        assign w_lane_valid_o[g]                 = main[g].lane_valid;
        assign w_we_o[g]                         = lane_we;
        assign w_rd_o[g*REG_AW +: REG_AW]        = main[g].rd;
        assign w_result_o[g*XLEN +: XLEN]        = lane_result;
    end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Scoreboard bench for mem_wb_skid_stage (LANES=2): expected bundles are
// queued at accept and compared when the stage transfers them.
module tb_mem_wb_skid_stage;

    localparam int LANES  = 2;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    m_valid_i;
    logic                    m_ready_o;
    logic [LANES-1:0]        m_lane_valid_i;
    logic [LANES-1:0]        m_flush_i;
    logic                    flush_all_i;
    logic [LANES-1:0]        m_regwrite_i;
    logic [LANES*2-1:0]      m_result_src_i;
    logic [LANES*XLEN-1:0]   m_alu_result_i;
    logic [LANES*XLEN-1:0]   m_read_data_i;
    logic [LANES*XLEN-1:0]   m_pc_plus8_i;
    logic [LANES*REG_AW-1:0] m_rd_i;
    logic                    w_valid_o;
    logic                    w_ready_i;
    logic [LANES-1:0]        w_lane_valid_o;
    logic [LANES-1:0]        w_we_o;
    logic [LANES*REG_AW-1:0] w_rd_o;
    logic [LANES*XLEN-1:0]   w_result_o;

    typedef struct {
        logic [LANES-1:0]        lv;
        logic [LANES-1:0]        we;
        logic [LANES*REG_AW-1:0] rd;
        logic [LANES*XLEN-1:0]   res;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic mon_en = 1'b0;

    mem_wb_skid_stage #(.LANES(LANES), .XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m_valid_i      (m_valid_i),
        .m_ready_o      (m_ready_o),
        .m_lane_valid_i (m_lane_valid_i),
        .m_flush_i      (m_flush_i),
        .flush_all_i    (flush_all_i),
        .m_regwrite_i   (m_regwrite_i),
        .m_result_src_i (m_result_src_i),
        .m_alu_result_i (m_alu_result_i),
        .m_read_data_i  (m_read_data_i),
        .m_pc_plus8_i   (m_pc_plus8_i),
        .m_rd_i         (m_rd_i),
        .w_valid_o      (w_valid_o),
        .w_ready_i      (w_ready_i),
        .w_lane_valid_o (w_lane_valid_o),
        .w_we_o         (w_we_o),
        .w_rd_o         (w_rd_o),
        .w_result_o     (w_result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] sel(input logic [1:0] s, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] m, input logic [XLEN-1:0] p);
        case (s)
            2'b00:   return a;
            2'b01:   return m;
            2'b10:   return p;
            default: return '0;
        endcase
    endfunction

    // Present one bundle, wait (bounded) for acceptance, then queue its expectation
    task automatic drive(input logic [1:0] lv, input logic [1:0] fl, input logic [1:0] rw,
                         input logic [3:0] src, input logic [63:0] alu, input logic [63:0] mem,
                         input logic [63:0] pc8, input logic [9:0] rd);
        exp_t e;
        bit   ok = 0;
        m_valid_i      = 1'b1;
        m_lane_valid_i = lv;
        m_flush_i      = fl;
        m_regwrite_i   = rw;
        m_result_src_i = src;
        m_alu_result_i = alu;
        m_read_data_i  = mem;
        m_pc_plus8_i   = pc8;
        m_rd_i         = rd;
        for (int l = 0; l < LANES; l++) begin
            if (fl[l]) begin
                e.lv[l] = 1'b0;
                e.we[l] = 1'b0;
                e.rd[l*REG_AW +: REG_AW] = '0;
                e.res[l*XLEN +: XLEN]    = '0;
            end else begin
                e.lv[l] = lv[l];
                e.we[l] = lv[l] & rw[l] & (rd[l*REG_AW +: REG_AW] != 0);
                e.rd[l*REG_AW +: REG_AW] = rd[l*REG_AW +: REG_AW];
                e.res[l*XLEN +: XLEN] = sel(src[l*2 +: 2], alu[l*XLEN +: XLEN],
                                            mem[l*XLEN +: XLEN], pc8[l*XLEN +: XLEN]);
            end
        end
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (m_ready_o) ok = 1;
            else @(posedge clk);
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        else q.push_back(e);
        @(posedge clk);
        #1;
        m_valid_i = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare every transferred bundle against the head of the scoreboard
    always @(negedge clk) begin
        if (mon_en && rst_n && !flush_all_i && w_valid_o && w_ready_i) begin
            if (q.size() == 0) begin
                check("spurious_bundle", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("lane_valid", 64'(w_lane_valid_o), 64'(e.lv));
                check("we", 64'(w_we_o), 64'(e.we));
                check("rd", 64'(w_rd_o), 64'(e.rd));
                check("result", w_result_o, e.res);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush_all_i = 1'b0; w_ready_i = 1'b1;
        m_valid_i = 1'b1; m_lane_valid_i = 2'b11; m_flush_i = '0; m_regwrite_i = 2'b11;
        m_result_src_i = '0; m_alu_result_i = {32'h55, 32'h66};
        m_read_data_i = '0; m_pc_plus8_i = '0; m_rd_i = {5'd3, 5'd4};
        cycles(2);
        check("rst_w_valid", 64'(w_valid_o), 64'd0);
        check("rst_lane_valid", 64'(w_lane_valid_o), 64'd0);
        check("rst_we", 64'(w_we_o), 64'd0);
        check("rst_rd", 64'(w_rd_o), 64'd0);
        check("rst_result", w_result_o, 64'd0);
        check("rst_m_ready", 64'(m_ready_o), 64'd1);
        m_valid_i = 1'b0;
        rst_n = 1'b1;
        cycles(1);
        check("no_capture", 64'(w_valid_o), 64'd0);
        mon_en = 1'b1;

        // streaming, one cycle latency
        drive(2'b11, 2'b00, 2'b11, 4'b0000, {32'h11, 32'h10}, '0, '0, {5'd2, 5'd1});
        check("latency", 64'(w_valid_o), 64'd1);
        drive(2'b11, 2'b00, 2'b11, 4'b0000, {32'h21, 32'h20}, '0, '0, {5'd2, 5'd1});
        drive(2'b11, 2'b00, 2'b11, 4'b0000, {32'h31, 32'h30}, '0, '0, {5'd2, 5'd1});
        cycles(2);
        check("stream_drain", 64'(w_valid_o), 64'd0);

        // skid: A then B while stalled
        w_ready_i = 1'b0;
        drive(2'b11, 2'b00, 2'b11, 4'b0000, {32'hA1, 32'hA0}, '0, '0, {5'd6, 5'd5});
        drive(2'b11, 2'b00, 2'b11, 4'b0000, {32'hB1, 32'hB0}, '0, '0, {5'd8, 5'd7});
        check("skid_ready_low", 64'(m_ready_o), 64'd0);
        check("skid_hold_a", w_result_o, {32'hA1, 32'hA0});
        cycles(2);
        check("skid_hold_a2", w_result_o, {32'hA1, 32'hA0});
        w_ready_i = 1'b1;
        cycles(1);
        check("release_ready", 64'(m_ready_o), 64'd1);
        check("release_b", w_result_o, {32'hB1, 32'hB0});
        cycles(2);

        // lane flush, x0 filter, result select, empty bundle
        drive(2'b11, 2'b10, 2'b11, 4'b0000, {32'h99, 32'h77}, '0, '0, {5'd9, 5'd0});
        drive(2'b11, 2'b00, 2'b11, 4'b1001, {32'h0, 32'h0}, {32'h0, 32'hDEADBEEF},
              {32'h108, 32'h0}, {5'd4, 5'd3});
        drive(2'b11, 2'b00, 2'b11, 4'b1111, {32'h1, 32'h2}, {32'h3, 32'h4},
              {32'h5, 32'h6}, {5'd4, 5'd3});
        drive(2'b00, 2'b00, 2'b00, 4'b0000, {32'h7, 32'h8}, '0, '0, {5'd1, 5'd1});
        cycles(2);

        // flush_all in SKID with a simultaneous incoming bundle
        w_ready_i = 1'b0;
        drive(2'b11, 2'b00, 2'b11, 4'b0000, {32'hC1, 32'hC0}, '0, '0, {5'd1, 5'd2});
        drive(2'b11, 2'b00, 2'b11, 4'b0000, {32'hD1, 32'hD0}, '0, '0, {5'd1, 5'd2});
        check("pre_flush_skid", 64'(m_ready_o), 64'd0);
        flush_all_i = 1'b1;
        m_valid_i   = 1'b1;
        q.delete();
        cycles(1);
        flush_all_i = 1'b0;
        m_valid_i   = 1'b0;
        check("flush_w_valid", 64'(w_valid_o), 64'd0);
        check("flush_m_ready", 64'(m_ready_o), 64'd1);
        w_ready_i = 1'b1;
        cycles(4);
        check("flush_stays_empty", 64'(w_valid_o), 64'd0);

        // reset mid-operation drops both entries
        w_ready_i = 1'b0;
        drive(2'b01, 2'b00, 2'b01, 4'b0000, {32'h0, 32'hE0}, '0, '0, {5'd0, 5'd1});
        drive(2'b01, 2'b00, 2'b01, 4'b0000, {32'h0, 32'hF0}, '0, '0, {5'd0, 5'd1});
        rst_n = 1'b0;
        q.delete();
        cycles(1);
        rst_n = 1'b1;
        check("midrst_w_valid", 64'(w_valid_o), 64'd0);
        check("midrst_m_ready", 64'(m_ready_o), 64'd1);
        w_ready_i = 1'b1;
        cycles(3);

        check("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
